jump_ctrl: RTL and testbench
============================

# jump_ctrl

Sequencing controller for all MIX jump instructions: opcode 39 (JMP…JLE) and opcodes 40–47 (JA, J1–J6, JX). It sits between the instruction decoder and the PC/rJ/overflow registers, and reads the register file through a synchronous read port. Register-sign/zero/parity tests are delegated to the existing `jmpr` condition unit. It returns one `done` pulse per accepted instruction, together with the PC, rJ and overflow update strobes.

## Interface

Parameters: none.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `opcode`  in  6  C field of the instruction
- `field`  in  6  F field of the instruction
- `m`  in  12  effective address (jump target)
- `pc`  in  12  address of the next sequential instruction
- `ci`  in  2  comparison indicator (encoding in `mix_defs.vh`)
- `ov`  in  1  overflow toggle
- `reg_rd_sel`  out  3  register-file select: 0=rA, 1–6=rI1–rI6, 7=rX
- `reg_rd_data`  in  31  sign at bit 30, magnitude in bits 29:0; valid the cycle after `reg_rd_sel`; index registers arrive zero-extended
- `busy`  out  1  high from the cycle after acceptance through DONE
- `done`  out  1  one-cycle completion pulse
- `pc_load`  out  1  jump taken; load `pc_next`
- `pc_next`  out  12  jump target (= latched `m`)
- `rj_load`  out  1  load `rj_value` into rJ
- `rj_value`  out  12  latched `pc`
- `ov_clear`  out  1  clear the overflow toggle
- `illegal`  out  1  unsupported opcode/field; no loads occur

## Operation

- States: IDLE, READ, EVAL, DONE.
- **IDLE**
  - On `start`, latch `opcode`, `field`, `m` and `pc`.
  - Opcode 39 → EVAL.
  - Opcodes 40–47 → READ.
  - Any other opcode → DONE with `illegal`.
- **READ**
  - Drive `reg_rd_sel = opcode - 40`, then → EVAL.
  - Outside READ, `reg_rd_sel` holds 0.
- **EVAL**: sample `ci` and `ov`, compute the decision, → DONE. Opcode 39 fields:
  - 0 JMP: taken, loads rJ.
  - 1 JSJ: taken, no rJ load.
  - 2 JOV: taken if `ov`.
  - 3 JNOV: taken if !`ov`.
  - For fields 2 and 3, `ov_clear` = sampled `ov` (the toggle is always off afterwards).
  - 4 JL, 5 JE, 6 JG: taken on the matching `ci`.
  - 7 JGE, 8 JNE, 9 JLE: taken on the complementary `ci`.
  - Field > 9: `illegal`.
- **EVAL, opcodes 40–47**
  - Field > 7: `illegal`.
  - Otherwise `jmpr` (sel=1, in=`reg_rd_data`, field=`field[2:0]`) decides.
  - Minus zero counts as zero for N/Z/P tests.
  - Parity (fields 6 and 7) looks at bit 0 of the magnitude only.
- **Taken jump**
  - `pc_load = 1`.
  - `rj_load = 1`, except for JSJ.
  - Not-taken jumps assert neither strobe.
- **DONE**: assert `done` plus the registered strobes for exactly one cycle, → IDLE.

## Timing

- All outputs are registered. Reset value of every output is 0, including `pc_next`, `rj_value` and `reg_rd_sel`.
- Opcode 39 or illegal opcode: `start` sampled in cycle 0; `done` in cycle 2.
- Opcodes 40–47: `reg_rd_sel` valid in cycle 1, data sampled in cycle 2, `done` in cycle 3.
- `start` while `busy` is ignored and the instruction is lost. The decoder must wait for `done`.
- `start` in the same cycle as `done` is also ignored. The earliest new acceptance is the cycle after `done`.
- `ci`, `ov` and `reg_rd_data` are sampled only in EVAL. Later changes do not affect the result.
- `rst` in any state: next cycle IDLE, all outputs 0, no strobe emitted for the aborted instruction.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure

- `mix_defs.vh` holds:
  - opcode constants `OP_JMP = 39`, `OP_JA = 40`, `OP_JX = 47`
  - `ci` encodings `CI_EQ = 2'b00`, `CI_GT = 2'b01`, `CI_LT = 2'b10`
  - state encodings
- One sub-module instance: `jmpr` for register conditions. The opcode-39 decode is inline.

## Test plan

- Opcode 40, field 0 (JAN), `reg_rd_data = {1'b1, 30'd5}`, `m = 100`, `pc = 7`:
  - `reg_rd_sel = 0` in cycle 1.
  - `done` in cycle 3 with `pc_load = 1`, `pc_next = 100`, `rj_load = 1`, `rj_value = 7`.
- Opcode 45, field 1 (J5Z), data = minus zero `{1'b1, 30'd0}`:
  - `reg_rd_sel = 5`.
  - Jump taken in cycle 3.
  - Repeat with field 0: no loads, `done = 1`.
- Opcode 39, field 2 (JOV), `ov = 1`: cycle 2 shows `pc_load = 1`, `rj_load = 1`, `ov_clear = 1`.
- Opcode 39, field 3 (JNOV), `ov = 1`: cycle 2 shows `ov_clear = 1`, `pc_load = 0`.
- Opcode 39, field 1 (JSJ): `pc_load = 1`, `rj_load = 0`.
- Opcode 39, fields 4–9 with `ci` = each of LT/EQ/GT: taken matches the truth table for all 18 cases.
- Opcode 39, field 12: `illegal = 1` in cycle 2, no strobes.
- Opcode 46, field 9: `illegal = 1` in cycle 3, no strobes.
- Back-to-back requests:
  - `start` held high continuously: one acceptance per completion (every 3 or 4 cycles).
  - `start` in the `done` cycle is ignored.
- `rst` asserted in READ: next cycle IDLE, all outputs 0, no `done`.
- A new `start` after reset completes normally.

Source files
------------

// File: rtl/jump_ctrl_pkg.sv
// jump_ctrl_pkg
// Shared definitions for the MIX jump controller: opcode constants,
// comparison-indicator encodings, controller state encoding and a small
// opcode-class helper. Imported by jump_ctrl and jmpr.
package jump_ctrl_pkg;

    // Opcode constants (C field)
    localparam logic [5:0] OP_JMP = 6'd39;
    localparam logic [5:0] OP_JA  = 6'd40;
    localparam logic [5:0] OP_JX  = 6'd47;

    // Comparison indicator encodings
    localparam logic [1:0] CI_EQ = 2'b00;
    localparam logic [1:0] CI_GT = 2'b01;
    localparam logic [1:0] CI_LT = 2'b10;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // True for the register-test jumps JA, J1..J6, JX
    function automatic logic is_reg_jump(input logic [5:0] op);
        return (op >= OP_JA) && (op <= OP_JX);
    endfunction

endpackage

// File: rtl/jump_ctrl_jmpr.sv
// jmpr
// Register condition unit for MIX register jumps (JrN..JrO).
// Ports:
//   sel    in  1   evaluate enable; taken is forced low when clear
//   value  in  31  register word, sign at bit 30, magnitude in 29:0
//   field  in  3   F field: 0 N, 1 Z, 2 P, 3 NN, 4 NZ, 5 NP, 6 E, 7 O
//   taken  out 1   condition holds
module jmpr
    import jump_ctrl_pkg::*;
(
    input  logic        sel,
    input  logic [30:0] value,
    input  logic [2:0]  field,
    output logic        taken
);

    logic mag_zero;
    logic is_neg;
    logic is_pos;
    logic cond;

    // Minus zero has a zero magnitude, so it is neither negative nor
    // positive and tests as zero. Parity looks only at magnitude bit 0.
    always_comb begin
        mag_zero = (value[29:0] == 30'd0);
        is_neg   = value[30] && !mag_zero;
        is_pos   = !value[30] && !mag_zero;
        cond     = 1'b0;
        case (field)
            3'd0:    cond = is_neg;
            3'd1:    cond = mag_zero;
            3'd2:    cond = is_pos;
            3'd3:    cond = !is_neg;
            3'd4:    cond = !mag_zero;
            3'd5:    cond = !is_pos;
            3'd6:    cond = !value[0];
            default: cond = value[0];
        endcase
        taken = sel && cond;
    end

endmodule

// File: rtl/jump_ctrl.sv
// jump_ctrl
// Sequencing controller for all MIX jump instructions (opcode 39 and
// opcodes 40-47). Accepts one instruction in IDLE, optionally reads the
// register file, evaluates the jump condition and emits a one-cycle done
// pulse with the PC / rJ / overflow update strobes. All outputs registered.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request, sampled only in IDLE
//   opcode, field       C and F fields of the instruction
//   m, pc               jump target and next sequential address
//   ci, ov              comparison indicator and overflow toggle
//   reg_rd_sel          register-file select (0 rA, 1-6 rI1-rI6, 7 rX)
//   reg_rd_data         register word, valid the cycle after reg_rd_sel
//   busy, done          in-flight flag and completion pulse
//   pc_load, pc_next    jump taken strobe and target
//   rj_load, rj_value   rJ load strobe and value
//   ov_clear            clear the overflow toggle
//   illegal             unsupported opcode/field, no loads
module jump_ctrl
    import jump_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [5:0]  field,
    input  logic [11:0] m,
    input  logic [11:0] pc,
    input  logic [1:0]  ci,
    input  logic        ov,
    output logic [2:0]  reg_rd_sel,
    input  logic [30:0] reg_rd_data,
    output logic        busy,
    output logic        done,
    output logic        pc_load,
    output logic [11:0] pc_next,
    output logic        rj_load,
    output logic [11:0] rj_value,
    output logic        ov_clear,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [5:0]  field_q, field_d;
    logic [11:0] pc_next_q, pc_next_d;
    logic [11:0] rj_value_q, rj_value_d;
    logic [2:0]  reg_rd_sel_q, reg_rd_sel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pc_load_q, pc_load_d;
    logic        rj_load_q, rj_load_d;
    logic        ov_clear_q, ov_clear_d;
    logic        illegal_q, illegal_d;

    logic [5:0]  sel_offset;
    logic        reg_op_q;
    logic        jmpr_taken;
    logic        taken;
    logic        link;
    logic        bad;

    assign sel_offset = opcode - OP_JA;
    assign reg_op_q   = is_reg_jump(opcode_q);

    jmpr u_jmpr (
        .sel   (reg_op_q),
        .value (reg_rd_data),
        .field (field_q[2:0]),
        .taken (jmpr_taken)
    );

    // Next-state and output logic. Illegal opcodes are routed through EVAL
    // so that every non-register instruction completes with the same
    // two-cycle latency; the decision there flags them illegal.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        field_d      = field_q;
        pc_next_d    = pc_next_q;
        rj_value_d   = rj_value_q;
        reg_rd_sel_d = 3'd0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        pc_load_d    = 1'b0;
        rj_load_d    = 1'b0;
        ov_clear_d   = 1'b0;
        illegal_d    = 1'b0;
        taken        = 1'b0;
        link         = 1'b1;
        bad          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opcode_d   = opcode;
                    field_d    = field;
                    pc_next_d  = m;
                    rj_value_d = pc;
                    busy_d     = 1'b1;
                    if (is_reg_jump(opcode)) begin
                        state_d      = ST_READ;
                        reg_rd_sel_d = sel_offset[2:0];
                    end else begin
                        state_d = ST_EVAL;
                    end
                end
            end

            ST_READ: begin
                busy_d  = 1'b1;
                state_d = ST_EVAL;
            end

            ST_EVAL: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_DONE;
                if (opcode_q == OP_JMP) begin
                    case (field_q)
                        6'd0: taken = 1'b1;
                        6'd1: begin
                            taken = 1'b1;
                            link  = 1'b0;
                        end
                        6'd2: begin
                            taken      = ov;
                            ov_clear_d = ov;
                        end
                        6'd3: begin
                            taken      = !ov;
                            ov_clear_d = ov;
                        end
                        6'd4: taken = (ci == CI_LT);
                        6'd5: taken = (ci == CI_EQ);
                        6'd6: taken = (ci == CI_GT);
                        6'd7: taken = (ci != CI_LT);
                        6'd8: taken = (ci != CI_EQ);
                        6'd9: taken = (ci != CI_GT);
                        default: bad = 1'b1;
                    endcase
                end else if (reg_op_q) begin
                    if (field_q > 6'd7) begin
                        bad = 1'b1;
                    end else begin
                        taken = jmpr_taken;
                    end
                end else begin
                    bad = 1'b1;
                end
                illegal_d = bad;
                pc_load_d = taken && !bad;
                rj_load_d = taken && link && !bad;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            opcode_q     <= 6'd0;
            field_q      <= 6'd0;
            pc_next_q    <= 12'd0;
            rj_value_q   <= 12'd0;
            reg_rd_sel_q <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pc_load_q    <= 1'b0;
            rj_load_q    <= 1'b0;
            ov_clear_q   <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            field_q      <= field_d;
            pc_next_q    <= pc_next_d;
            rj_value_q   <= rj_value_d;
            reg_rd_sel_q <= reg_rd_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pc_load_q    <= pc_load_d;
            rj_load_q    <= rj_load_d;
            ov_clear_q   <= ov_clear_d;
            illegal_q    <= illegal_d;
        end
    end

    assign reg_rd_sel = reg_rd_sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pc_load    = pc_load_q;
    assign pc_next    = pc_next_q;
    assign rj_load    = rj_load_q;
    assign rj_value   = rj_value_q;
    assign ov_clear   = ov_clear_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// tb_jump_ctrl
// Directed testbench for jump_ctrl. Each instruction is launched with
// applyStimulus, which checks latency, strobes and latched values against
// hand-computed expectations through checkOutput.
module tb_jump_ctrl;

    localparam logic [1:0] T_CI_EQ = 2'b00;
    localparam logic [1:0] T_CI_GT = 2'b01;
    localparam logic [1:0] T_CI_LT = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic [5:0]  field;
    logic [11:0] m;
    logic [11:0] pc;
    logic [1:0]  ci;
    logic        ov;
    logic [2:0]  reg_rd_sel;
    logic [30:0] reg_rd_data;
    logic        busy;
    logic        done;
    logic        pc_load;
    logic [11:0] pc_next;
    logic        rj_load;
    logic [11:0] rj_value;
    logic        ov_clear;
    logic        illegal;

    int checkCount = 0;
    int passCount  = 0;

    jump_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .opcode      (opcode),
        .field       (field),
        .m           (m),
        .pc          (pc),
        .ci          (ci),
        .ov          (ov),
        .reg_rd_sel  (reg_rd_sel),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .done        (done),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .rj_load     (rj_load),
        .rj_value    (rj_value),
        .ov_clear    (ov_clear),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task checkOutput(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        else
            passCount++;
    endtask

    // Launch one instruction from IDLE and check it end to end
    task applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fld,
                       input logic [11:0] mv, input logic [11:0] pcv,
                       input logic [1:0] civ, input logic ovv, input logic [30:0] data,
                       input int expCycle, input logic expPc, input logic expRj,
                       input logic expOvc, input logic expIll, input logic [2:0] expSel);
        int cyc;
        @(negedge clk);
        opcode = op; field = fld; m = mv; pc = pcv;
        ci = civ; ov = ovv; reg_rd_data = data; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".busy1"}, 32'(busy), 32'd1);
        checkOutput({tag, ".sel1"}, 32'(reg_rd_sel), 32'(expSel));
        cyc = 1;
        while (done !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, ".doneCycle"}, 32'(cyc), 32'(expCycle));
        checkOutput({tag, ".pc_load"}, 32'(pc_load), 32'(expPc));
        checkOutput({tag, ".rj_load"}, 32'(rj_load), 32'(expRj));
        checkOutput({tag, ".ov_clear"}, 32'(ov_clear), 32'(expOvc));
        checkOutput({tag, ".illegal"}, 32'(illegal), 32'(expIll));
        checkOutput({tag, ".pc_next"}, 32'(pc_next), 32'(mv));
        checkOutput({tag, ".rj_value"}, 32'(rj_value), 32'(pcv));
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, ".busyAfter"}, 32'(busy), 32'd0);
    endtask

    logic [2:0] truthTbl [6];
    logic [1:0] ciVal;
    logic       expTaken;
    int         doneSeen;

    initial begin
        // bit2 = LT, bit1 = EQ, bit0 = GT for fields 4..9
        truthTbl = '{3'b100, 3'b010, 3'b001, 3'b011, 3'b101, 3'b110};

        rst = 1'b1; start = 1'b0; opcode = '0; field = '0; m = '0; pc = '0;
        ci = '0; ov = 1'b0; reg_rd_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.sel", 32'(reg_rd_sel), 32'd0);
        checkOutput("reset.pc_next", 32'(pc_next), 32'd0);
        checkOutput("reset.rj_value", 32'(rj_value), 32'd0);
        checkOutput("reset.strobes", 32'({pc_load, rj_load, ov_clear, illegal}), 32'd0);

        // Register jumps
        applyStimulus("JAN", 6'd40, 6'd0, 12'd100, 12'd7, T_CI_EQ, 1'b0, {1'b1, 30'd5},
                      3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus("J5Z", 6'd45, 6'd1, 12'd200, 12'd8, T_CI_EQ, 1'b0, {1'b1, 30'd0},
                      3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
        applyStimulus("J5N-mz", 6'd45, 6'd0, 12'd201, 12'd9, T_CI_EQ, 1'b0, {1'b1, 30'd0},
                      3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
        applyStimulus("J2E", 6'd42, 6'd6, 12'd300, 12'd10, T_CI_EQ, 1'b0, {1'b0, 30'd4},
                      3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        applyStimulus("JXO", 6'd47, 6'd7, 12'd301, 12'd11, T_CI_EQ, 1'b0, {1'b1, 30'd3},
                      3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
        applyStimulus("J3P-zero", 6'd43, 6'd2, 12'd302, 12'd12, T_CI_EQ, 1'b0, {1'b0, 30'd0},
                      3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        applyStimulus("J4NZ-mz", 6'd44, 6'd4, 12'd303, 12'd13, T_CI_EQ, 1'b0, {1'b1, 30'd0},
                      3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
        applyStimulus("JANP-neg", 6'd40, 6'd5, 12'd304, 12'd14, T_CI_EQ, 1'b0, {1'b1, 30'd5},
                      3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus("J1NN-pos", 6'd41, 6'd3, 12'd305, 12'd15, T_CI_EQ, 1'b0, {1'b0, 30'd9},
                      3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);

        // Opcode 39
        applyStimulus("JMP", 6'd39, 6'd0, 12'd400, 12'd20, T_CI_EQ, 1'b0, '0,
                      2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus("JOV", 6'd39, 6'd2, 12'd401, 12'd21, T_CI_EQ, 1'b1, '0,
                      2, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus("JNOV-ov1", 6'd39, 6'd3, 12'd402, 12'd22, T_CI_EQ, 1'b1, '0,
                      2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        applyStimulus("JNOV-ov0", 6'd39, 6'd3, 12'd403, 12'd23, T_CI_EQ, 1'b0, '0,
                      2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus("JSJ", 6'd39, 6'd1, 12'd404, 12'd24, T_CI_EQ, 1'b0, '0,
                      2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int f = 4; f <= 9; f++) begin
            for (int c = 0; c < 3; c++) begin
                ciVal = (c == 0) ? T_CI_LT : ((c == 1) ? T_CI_EQ : T_CI_GT);
                expTaken = truthTbl[f - 4][2 - c];
                applyStimulus($sformatf("CMP.f%0d.c%0d", f, c), 6'd39, 6'(f),
                              12'(500 + f), 12'(30 + c), ciVal, 1'b0, '0,
                              2, expTaken, expTaken, 1'b0, 1'b0, 3'd0);
            end
        end

        // Illegal cases
        applyStimulus("ILL-f12", 6'd39, 6'd12, 12'd600, 12'd40, T_CI_EQ, 1'b1, '0,
                      2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        applyStimulus("ILL-op46f9", 6'd46, 6'd9, 12'd601, 12'd41, T_CI_EQ, 1'b0, {1'b0, 30'd2},
                      3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
        applyStimulus("ILL-op38", 6'd38, 6'd0, 12'd602, 12'd42, T_CI_EQ, 1'b0, '0,
                      2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

        // start held high: opcode 39 completes every 3 cycles
        @(negedge clk);
        opcode = 6'd39; field = 6'd1; start = 1'b1;
        doneSeen = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        start = 1'b0;
        checkOutput("b2b.op39.dones", 32'(doneSeen), 32'd4);
        repeat (4) @(negedge clk);

        // start held high: register jumps complete every 4 cycles
        opcode = 6'd40; field = 6'd1; reg_rd_data = '0; start = 1'b1;
        doneSeen = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        start = 1'b0;
        checkOutput("b2b.op40.dones", 32'(doneSeen), 32'd3);
        repeat (5) @(negedge clk);

        // start raised only in the done cycle is dropped
        opcode = 6'd39; field = 6'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("doneStart.done", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("doneStart.busy3", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("doneStart.done4", 32'(done), 32'd0);
        checkOutput("doneStart.busy4", 32'(busy), 32'd0);

        // Reset while in READ aborts the instruction
        @(negedge clk);
        opcode = 6'd41; field = 6'd0; m = 12'd77; pc = 12'd55;
        reg_rd_data = {1'b1, 30'd1}; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("rstRead.sel1", 32'(reg_rd_sel), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstRead.busy", 32'(busy), 32'd0);
        checkOutput("rstRead.sel", 32'(reg_rd_sel), 32'd0);
        checkOutput("rstRead.pc_next", 32'(pc_next), 32'd0);
        checkOutput("rstRead.rj_value", 32'(rj_value), 32'd0);
        checkOutput("rstRead.strobes", 32'({done, pc_load, rj_load, ov_clear, illegal}), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("rstRead.noDone", 32'(doneSeen), 32'd0);

        // rst and start together: rst wins
        @(negedge clk);
        opcode = 6'd39; field = 6'd0; rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 begin rst = 1'b0; start = 1'b0; end
        @(negedge clk);
        checkOutput("rstStart.busy", 32'(busy), 32'd0);

        applyStimulus("afterRst", 6'd41, 6'd0, 12'd88, 12'd66, T_CI_EQ, 1'b0, {1'b1, 30'd1},
                      3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
